// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags, commit forwarding and a full-flush jump.
// Define REGFILE_CKPT_EN to build rename-table checkpoint slots for branch recovery.
module regfile_rename #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int ROB_LOG = 4,
  parameter int NRD     = 2,
  parameter int NCKPT   = 4,
  localparam int RLOG   = $clog2(NREG),
  localparam int CLOG   = $clog2(NCKPT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [NRD-1:0]        rs_valid,
  input  logic [NRD*RLOG-1:0]   rs,
  output logic [NRD*XLEN-1:0]   V_to_issue,
  output logic [NRD-1:0]        R_to_issue,
  output logic [NRD*ROB_LOG-1:0] Q_to_issue,
  input  logic                  commit_valid,
  input  logic [RLOG-1:0]       commit_dest,
  input  logic [XLEN-1:0]       commit_value,
  input  logic [ROB_LOG-1:0]    commit_RobId,
  input  logic                  rename_valid,
  input  logic [RLOG-1:0]       issue_rd,
  input  logic [ROB_LOG-1:0]    issue_RobId,
  input  logic                  jump_flag,
  input  logic                  ckpt_save,
  input  logic [CLOG-1:0]       ckpt_save_id,
  input  logic                  ckpt_restore,
  input  logic [CLOG-1:0]       ckpt_restore_id
);

  // All strobes are single-cycle and qualified by rdy; there are no valid/ready handshakes.
  logic [XLEN-1:0]    val_q   [NREG];
  logic [ROB_LOG-1:0] tag_q   [NREG];
  logic [ROB_LOG-1:0] tag_upd [NREG];
  logic [ROB_LOG-1:0] tag_nxt [NREG];

  // Read ports see pre-edge state; a matching commit forwards its value.
  always_comb begin
    logic [RLOG-1:0]    idx;
    logic [ROB_LOG-1:0] t;
    V_to_issue = '0;
    R_to_issue = '0;
    Q_to_issue = '0;
    idx        = '0;
    t          = '0;
    for (int i = 0; i < NRD; i++) begin
      idx = rs[i*RLOG +: RLOG];
      t   = tag_q[idx];
      if (rs_valid[i]) begin
        if (t == '0) begin
          V_to_issue[i*XLEN +: XLEN] = val_q[idx];
          R_to_issue[i]              = 1'b1;
        end else if (commit_valid && (commit_RobId == t)) begin
          V_to_issue[i*XLEN +: XLEN] = commit_value;
          R_to_issue[i]              = 1'b1;
        end else begin
          Q_to_issue[i*ROB_LOG +: ROB_LOG] = t;
        end
      end
    end
  end

  // Tag table after this cycle's commit clear and rename (rename wins); x0 never gets a tag.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      tag_upd[r] = tag_q[r];
      if (commit_valid && (commit_dest == RLOG'(r)) && (tag_q[r] == commit_RobId))
        tag_upd[r] = '0;
      if (rename_valid && (r != 0) && (issue_rd == RLOG'(r)))
        tag_upd[r] = issue_RobId;
    end
  end

`ifdef REGFILE_CKPT_EN
  logic [ROB_LOG-1:0] slot_q   [NCKPT][NREG];
  logic [ROB_LOG-1:0] slot_nxt [NCKPT][NREG];

  // Slots are scrubbed of the retiring tag on every commit so a restore never resurrects it.
  always_comb begin
    for (int s = 0; s < NCKPT; s++) begin
      for (int r = 0; r < NREG; r++) begin
        slot_nxt[s][r] = slot_q[s][r];
        if (commit_valid && (commit_dest == RLOG'(r)) && (slot_q[s][r] == commit_RobId))
          slot_nxt[s][r] = '0;
        if (ckpt_save && !ckpt_restore && !jump_flag && (ckpt_save_id == CLOG'(s)))
          slot_nxt[s][r] = tag_upd[r];
      end
    end
  end

  // The restored slot is never also saved this cycle, so its next value is just the scrubbed copy.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      if (jump_flag)
        tag_nxt[r] = '0;
      else if (ckpt_restore)
        tag_nxt[r] = slot_nxt[ckpt_restore_id][r];
      else
        tag_nxt[r] = tag_upd[r];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NCKPT; s++)
        for (int r = 0; r < NREG; r++)
          slot_q[s][r] <= '0;
    end else if (rdy) begin
      for (int s = 0; s < NCKPT; s++)
        for (int r = 0; r < NREG; r++)
          slot_q[s][r] <= slot_nxt[s][r];
    end
  end
`else
  logic ckpt_unused;
  assign ckpt_unused = ^{ckpt_save, ckpt_save_id, ckpt_restore, ckpt_restore_id};

  always_comb begin
    for (int r = 0; r < NREG; r++)
      tag_nxt[r] = jump_flag ? '0 : tag_upd[r];
  end
`endif

  // A flush clears tags but the same-cycle commit value is still written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
    end else if (rdy) begin
      for (int r = 0; r < NREG; r++)
        tag_q[r] <= tag_nxt[r];
      if (commit_valid && (commit_dest != '0))
        val_q[commit_dest] <= commit_value;
    end
  end

endmodule

// File: tb/tb_regfile_rename.sv
// Bench for regfile_rename: directed scenarios then random traffic against a register/tag array model.
module tb_regfile_rename;
  localparam int XLEN    = 32;
  localparam int NREG    = 32;
  localparam int ROB_LOG = 4;
  localparam int NRD     = 2;
  localparam int NCKPT   = 4;
  localparam int RLOG    = $clog2(NREG);
  localparam int CLOG    = $clog2(NCKPT);

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   rdy;
  logic [NRD-1:0]         rs_valid;
  logic [NRD*RLOG-1:0]    rs;
  logic [NRD*XLEN-1:0]    V_to_issue;
  logic [NRD-1:0]         R_to_issue;
  logic [NRD*ROB_LOG-1:0] Q_to_issue;
  logic                   commit_valid;
  logic [RLOG-1:0]        commit_dest;
  logic [XLEN-1:0]        commit_value;
  logic [ROB_LOG-1:0]     commit_RobId;
  logic                   rename_valid;
  logic [RLOG-1:0]        issue_rd;
  logic [ROB_LOG-1:0]     issue_RobId;
  logic                   jump_flag;
  logic                   ckpt_save;
  logic [CLOG-1:0]        ckpt_save_id;
  logic                   ckpt_restore;
  logic [CLOG-1:0]        ckpt_restore_id;

  logic [RLOG-1:0] rsi [NRD];

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: committed values, newest producer tags, checkpoint copies.
  logic [XLEN-1:0]    m_val  [NREG];
  logic [ROB_LOG-1:0] m_tag  [NREG];
  logic [ROB_LOG-1:0] m_slot [NCKPT][NREG];

  always #5 clk = ~clk;

  always_comb begin
    rs = '0;
    for (int i = 0; i < NRD; i++) rs[i*RLOG +: RLOG] = rsi[i];
  end

  regfile_rename #(.XLEN(XLEN), .NREG(NREG), .ROB_LOG(ROB_LOG), .NRD(NRD), .NCKPT(NCKPT)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rs_valid(rs_valid), .rs(rs),
    .V_to_issue(V_to_issue), .R_to_issue(R_to_issue), .Q_to_issue(Q_to_issue),
    .commit_valid(commit_valid), .commit_dest(commit_dest),
    .commit_value(commit_value), .commit_RobId(commit_RobId),
    .rename_valid(rename_valid), .issue_rd(issue_rd), .issue_RobId(issue_RobId),
    .jump_flag(jump_flag),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id)
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d]: got %0h expected %0h", nm, idx, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_val[r] = '0;
      m_tag[r] = '0;
      for (int s = 0; s < NCKPT; s++) m_slot[s][r] = '0;
    end
  endtask

  task automatic idle();
    rdy = 1'b1;
    rs_valid = '0;
    for (int i = 0; i < NRD; i++) rsi[i] = '0;
    commit_valid = 1'b0; commit_dest = '0; commit_value = '0; commit_RobId = '0;
    rename_valid = 1'b0; issue_rd = '0; issue_RobId = '0;
    jump_flag = 1'b0;
    ckpt_save = 1'b0; ckpt_save_id = '0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
  endtask

  task automatic rd(input int p, input int r);
    rs_valid[p] = 1'b1;
    rsi[p]      = RLOG'(r);
  endtask

  // Expected operand: not requested / no producer / producer committing now / waiting.
  task automatic check_reads();
    for (int i = 0; i < NRD; i++) begin
      logic [XLEN-1:0]    ev;
      logic               er;
      logic [ROB_LOG-1:0] eq;
      int                 r;
      r  = int'(rsi[i]);
      ev = '0; er = 1'b0; eq = '0;
      if (rs_valid[i]) begin
        if (r == 0) begin
          er = 1'b1;
        end else if (m_tag[r] == 0) begin
          ev = m_val[r]; er = 1'b1;
        end else if (commit_valid && commit_RobId == m_tag[r]) begin
          ev = commit_value; er = 1'b1;
        end else begin
          eq = m_tag[r];
        end
      end
      chk("V", i, V_to_issue[i*XLEN +: XLEN], ev);
      chk("R", i, 32'(R_to_issue[i]), 32'(er));
      chk("Q", i, 32'(Q_to_issue[i*ROB_LOG +: ROB_LOG]), 32'(eq));
    end
  endtask

  task automatic model_edge();
    logic [ROB_LOG-1:0] upd  [NREG];
    logic [ROB_LOG-1:0] rest [NREG];
    if (!rdy) return;
    if (commit_valid && commit_dest != 0) m_val[commit_dest] = commit_value;
    for (int r = 0; r < NREG; r++) upd[r] = m_tag[r];
    if (commit_valid && m_tag[commit_dest] == commit_RobId) upd[commit_dest] = '0;
    if (rename_valid && issue_rd != 0) upd[issue_rd] = issue_RobId;
    for (int r = 0; r < NREG; r++) rest[r] = upd[r];
`ifdef REGFILE_CKPT_EN
    for (int r = 0; r < NREG; r++) rest[r] = m_slot[ckpt_restore_id][r];
    if (commit_valid && rest[commit_dest] == commit_RobId) rest[commit_dest] = '0;
    for (int s = 0; s < NCKPT; s++)
      if (commit_valid && m_slot[s][commit_dest] == commit_RobId) m_slot[s][commit_dest] = '0;
    if (ckpt_save && !ckpt_restore && !jump_flag)
      for (int r = 0; r < NREG; r++) m_slot[ckpt_save_id][r] = upd[r];
    if (!ckpt_restore)
      for (int r = 0; r < NREG; r++) rest[r] = upd[r];
`endif
    for (int r = 0; r < NREG; r++) m_tag[r] = jump_flag ? '0 : rest[r];
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic cyc();
    #1;
    check_reads();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    idle();
    model_reset();
    rd(0, 5);
    #2;
    check_reads();
    @(negedge clk);
    rst = 1'b1;

    // x5 after reset, then commit to x0 must not stick
    idle(); rd(0, 5); cyc();
    idle(); commit_valid = 1'b1; commit_dest = 0; commit_value = 32'hDEAD; commit_RobId = 4'd1; cyc();
    idle(); rd(0, 0); rd(1, 5); cyc();

    // rename x3 -> 5, wait, commit with forwarding, then settled
    idle(); rename_valid = 1'b1; issue_rd = 3; issue_RobId = 4'd5; cyc();
    idle(); rd(0, 3); cyc();
    idle(); rd(0, 3); commit_valid = 1'b1; commit_dest = 3; commit_value = 32'h1234; commit_RobId = 4'd5; cyc();
    idle(); rd(0, 3); rd(1, 3); cyc();

    // commit x7 tag 2 while renaming x7 to 6
    idle(); rename_valid = 1'b1; issue_rd = 7; issue_RobId = 4'd2; cyc();
    idle(); rd(0, 7); commit_valid = 1'b1; commit_dest = 7; commit_value = 32'h77; commit_RobId = 4'd2;
    rename_valid = 1'b1; issue_rd = 7; issue_RobId = 4'd6; cyc();
    idle(); rd(0, 7); cyc();

    // stale commit to x4
    idle(); rename_valid = 1'b1; issue_rd = 4; issue_RobId = 4'd3; cyc();
    idle(); commit_valid = 1'b1; commit_dest = 4; commit_value = 32'd9; commit_RobId = 4'd1; cyc();
    idle(); rd(0, 4); rd(1, 7); cyc();
    idle(); jump_flag = 1'b1; rename_valid = 1'b1; issue_rd = 9; issue_RobId = 4'd4; cyc();
    idle(); rd(0, 4); rd(1, 7); cyc();
    idle(); rd(0, 9); cyc();

    // checkpoint save/restore with scrubbing of the retired tag
    idle(); rename_valid = 1'b1; issue_rd = 1; issue_RobId = 4'd2; cyc();
    idle(); ckpt_save = 1'b1; ckpt_save_id = 2'd1; cyc();
    idle(); rename_valid = 1'b1; issue_rd = 1; issue_RobId = 4'd7; cyc();
    idle(); rd(0, 1); commit_valid = 1'b1; commit_dest = 1; commit_value = 32'h55; commit_RobId = 4'd2; cyc();
    idle(); ckpt_restore = 1'b1; ckpt_restore_id = 2'd1; rd(0, 1); cyc();
    idle(); rd(0, 1); cyc();

    // jump with restore, then a commit under rdy=0
    idle(); rename_valid = 1'b1; issue_rd = 2; issue_RobId = 4'd8; cyc();
    idle(); ckpt_save = 1'b1; ckpt_save_id = 2'd2; cyc();
    idle(); jump_flag = 1'b1; ckpt_restore = 1'b1; ckpt_restore_id = 2'd2; cyc();
    idle(); rd(0, 2); rename_valid = 1'b1; issue_rd = 2; issue_RobId = 4'd8; cyc();
    idle(); rdy = 1'b0; rd(0, 2); commit_valid = 1'b1; commit_dest = 2; commit_value = 32'hBEEF; commit_RobId = 4'd8; cyc();
    idle(); rd(0, 2); rd(1, 2); cyc();

    // random traffic with a mid-run asynchronous reset
    for (int n = 0; n < 500; n++) begin
      idle();
      if (n == 250) begin
        rst = 1'b0;
        rs_valid = '1;
        for (int i = 0; i < NRD; i++) rsi[i] = RLOG'($urandom_range(0, NREG-1));
        #1;
        model_reset();
        check_reads();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle();
      end
      rdy = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < NRD; i++) begin
        rs_valid[i] = $urandom_range(0, 3) != 0;
        rsi[i] = RLOG'(($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, NREG-1));
      end
      commit_valid = $urandom_range(0, 1) == 1;
      commit_dest  = ($urandom_range(0, 2) == 0) ? rsi[0] : RLOG'($urandom_range(0, 7));
      commit_value = $urandom;
      if ($urandom_range(0, 3) != 0 && m_tag[commit_dest] != 0)
        commit_RobId = m_tag[commit_dest];
      else
        commit_RobId = ROB_LOG'($urandom_range(1, (1 << ROB_LOG) - 1));
      rename_valid = $urandom_range(0, 1) == 1;
      issue_rd     = RLOG'($urandom_range(0, 7));
      issue_RobId  = ROB_LOG'($urandom_range(1, (1 << ROB_LOG) - 1));
      jump_flag    = $urandom_range(0, 29) == 0;
      ckpt_save       = $urandom_range(0, 4) == 0;
      ckpt_save_id    = CLOG'($urandom_range(0, NCKPT-1));
      ckpt_restore    = $urandom_range(0, 9) == 0;
      ckpt_restore_id = CLOG'($urandom_range(0, NCKPT-1));
      cyc();
    end

    // final sweep of every register
    for (int r = 0; r < NREG; r += NRD) begin
      idle();
      for (int i = 0; i < NRD; i++) rd(i, r + i);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
